// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter and sequencer in front of MAIN_MEMORY.
// Latency: strobe one cycle after the request is sampled in IDLE; ACK one cycle after MemACK;
//          timeout after TIMEOUT_CYCLES BUSY cycles.
// Backpressure: a requester holds its level request until its ACK pulse; losers wait in place.
//
// Ports:
//   MEM_ARBITER_CLOCK_50 / MEM_ARBITER_ResetInLow_In : clock, synchronous active-low reset
//   MEM_ARBITER_ReqN_RD_In / _WR_In                   : requester N read / write level request
//   MEM_ARBITER_ReqN_A_InBus / _B_InBus               : requester N address / write data
//   MEM_ARBITER_ReqN_ACK_Out / _Error_Out             : requester N completion pulse / timeout flag
//   MEM_ARBITER_Data_OutBus                           : read data of the last completed access
//   MEM_ARBITER_MemRD_Out / _MemWRMain_Out            : memory strobes, held for the whole access
//   MEM_ARBITER_MemA_OutBus / _MemB_OutBus            : memory address / write data
//   MEM_ARBITER_MemACK_In / _MemData_InBus            : memory acknowledge / read data
//   MEM_ARBITER_Grant_OutBus                          : one-hot owner during the access (01/10/00)
module mem_arbiter #(
  parameter int DATAWIDTH_BUS  = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMEOUT_WIDTH  = 5
) (
  input  logic                     MEM_ARBITER_CLOCK_50,
  input  logic                     MEM_ARBITER_ResetInLow_In,
  input  logic                     MEM_ARBITER_Req0_RD_In,
  input  logic                     MEM_ARBITER_Req0_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_Req0_A_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_Req0_B_InBus,
  output logic                     MEM_ARBITER_Req0_ACK_Out,
  output logic                     MEM_ARBITER_Req0_Error_Out,
  input  logic                     MEM_ARBITER_Req1_RD_In,
  input  logic                     MEM_ARBITER_Req1_WR_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_Req1_A_InBus,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_Req1_B_InBus,
  output logic                     MEM_ARBITER_Req1_ACK_Out,
  output logic                     MEM_ARBITER_Req1_Error_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_Data_OutBus,
  output logic                     MEM_ARBITER_MemRD_Out,
  output logic                     MEM_ARBITER_MemWRMain_Out,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemA_OutBus,
  output logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemB_OutBus,
  input  logic                     MEM_ARBITER_MemACK_In,
  input  logic [DATAWIDTH_BUS-1:0] MEM_ARBITER_MemData_InBus,
  output logic [1:0]               MEM_ARBITER_Grant_OutBus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  // state and captured transaction
  state_t                   state_q, state_d;
  logic                     owner_q, owner_d;   // 0 = req0, 1 = req1
  logic                     op_wr_q, op_wr_d;   // 1 = write, 0 = read
  logic                     last_q, last_d;     // round-robin pointer: last served requester
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATAWIDTH_BUS-1:0] addr_q, addr_d;
  logic [DATAWIDTH_BUS-1:0] wdata_q, wdata_d;

  // registered outputs
  logic                     mem_rd_q, mem_rd_d;
  logic                     mem_wr_q, mem_wr_d;
  logic                     ack0_q, ack0_d;
  logic                     ack1_q, ack1_d;
  logic                     err0_q, err0_d;
  logic                     err1_q, err1_d;
  logic [1:0]               grant_q, grant_d;
  logic [DATAWIDTH_BUS-1:0] data_q, data_d;

  // arbitration terms
  logic req0, req1;
  logic win1;
  logic win_wr;

  assign req0 = MEM_ARBITER_Req0_RD_In | MEM_ARBITER_Req0_WR_In;
  assign req1 = MEM_ARBITER_Req1_RD_In | MEM_ARBITER_Req1_WR_In;

  // req1 wins when it is alone, or on a tie when req0 was served last.
  assign win1 = req1 & (~req0 | ~last_q);

  // RD and WR together is a read, so a write needs WR without RD.
  assign win_wr = win1 ? (MEM_ARBITER_Req1_WR_In & ~MEM_ARBITER_Req1_RD_In)
                       : (MEM_ARBITER_Req0_WR_In & ~MEM_ARBITER_Req0_RD_In);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    op_wr_d  = op_wr_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    data_d   = data_q;
    mem_rd_d = 1'b0;
    mem_wr_d = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    grant_d  = 2'b00;

    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          owner_d  = win1;
          op_wr_d  = win_wr;
          addr_d   = win1 ? MEM_ARBITER_Req1_A_InBus : MEM_ARBITER_Req0_A_InBus;
          wdata_d  = win1 ? MEM_ARBITER_Req1_B_InBus : MEM_ARBITER_Req0_B_InBus;
          cnt_d    = '0;
          state_d  = ST_BUSY;
          mem_rd_d = ~win_wr;
          mem_wr_d = win_wr;
          grant_d  = win1 ? 2'b10 : 2'b01;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
        // An acknowledge in the final counted cycle still completes normally.
        if (MEM_ARBITER_MemACK_In) begin
          data_d  = op_wr_q ? '0 : MEM_ARBITER_MemData_InBus;
          state_d = ST_RESP;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = '0;
          state_d = ST_RESP;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          err0_d  = ~owner_q;
          err1_d  = owner_q;
        end else begin
          mem_rd_d = ~op_wr_q;
          mem_wr_d = op_wr_q;
          grant_d  = owner_q ? 2'b10 : 2'b01;
        end
      end

      ST_RESP: begin
        last_d  = owner_q;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge MEM_ARBITER_CLOCK_50) begin
    if (!MEM_ARBITER_ResetInLow_In) begin
      state_q  <= ST_IDLE;
      owner_q  <= 1'b0;
      op_wr_q  <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      grant_q  <= 2'b00;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      op_wr_q  <= op_wr_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      data_q   <= data_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      grant_q  <= grant_d;
    end
  end

  assign MEM_ARBITER_Req0_ACK_Out   = ack0_q;
  assign MEM_ARBITER_Req0_Error_Out = err0_q;
  assign MEM_ARBITER_Req1_ACK_Out   = ack1_q;
  assign MEM_ARBITER_Req1_Error_Out = err1_q;
  assign MEM_ARBITER_Data_OutBus    = data_q;
  assign MEM_ARBITER_MemRD_Out      = mem_rd_q;
  assign MEM_ARBITER_MemWRMain_Out  = mem_wr_q;
  assign MEM_ARBITER_MemA_OutBus    = addr_q;
  assign MEM_ARBITER_MemB_OutBus    = wdata_q;
  assign MEM_ARBITER_Grant_OutBus   = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// A memory model answers after an address-dependent delay; drivers push expected results,
// a negedge monitor checks grants, memory-side fields, strobe length, ACK timing and responses.
module tb_mem_arbiter;

  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rd0, wr0, rd1, wr1;
  logic [DW-1:0] a0, b0, a1, b1;
  logic          ack0, err0, ack1, err1;
  logic [DW-1:0] data_out;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_a, mem_b;
  logic          mem_ack;
  logic [DW-1:0] mem_data;
  logic [1:0]    grant;

  always #5 clk = ~clk;

  mem_arbiter #(.DATAWIDTH_BUS(DW), .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(5)) dut (
    .MEM_ARBITER_CLOCK_50      (clk),
    .MEM_ARBITER_ResetInLow_In (rst_n),
    .MEM_ARBITER_Req0_RD_In    (rd0),
    .MEM_ARBITER_Req0_WR_In    (wr0),
    .MEM_ARBITER_Req0_A_InBus  (a0),
    .MEM_ARBITER_Req0_B_InBus  (b0),
    .MEM_ARBITER_Req0_ACK_Out  (ack0),
    .MEM_ARBITER_Req0_Error_Out(err0),
    .MEM_ARBITER_Req1_RD_In    (rd1),
    .MEM_ARBITER_Req1_WR_In    (wr1),
    .MEM_ARBITER_Req1_A_InBus  (a1),
    .MEM_ARBITER_Req1_B_InBus  (b1),
    .MEM_ARBITER_Req1_ACK_Out  (ack1),
    .MEM_ARBITER_Req1_Error_Out(err1),
    .MEM_ARBITER_Data_OutBus   (data_out),
    .MEM_ARBITER_MemRD_Out     (mem_rd),
    .MEM_ARBITER_MemWRMain_Out (mem_wr),
    .MEM_ARBITER_MemA_OutBus   (mem_a),
    .MEM_ARBITER_MemB_OutBus   (mem_b),
    .MEM_ARBITER_MemACK_In     (mem_ack),
    .MEM_ARBITER_MemData_InBus (mem_data),
    .MEM_ARBITER_Grant_OutBus  (grant)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference rules ----------------
  // Address low bits select memory behaviour: 1F never answers, 1E answers in
  // the last allowed cycle, 1D one cycle earlier, others after 1..4 cycles.
  function automatic bit is_tmo(input logic [DW-1:0] a);
    return a[4:0] == 5'h1F;
  endfunction

  function automatic int ack_delay(input logic [DW-1:0] a);
    if (a[4:0] == 5'h1F) return 0;
    if (a[4:0] == 5'h1E) return TMO;
    if (a[4:0] == 5'h1D) return TMO - 1;
    return 1 + int'(a[1:0]);
  endfunction

  function automatic int strobe_len(input logic [DW-1:0] a);
    return is_tmo(a) ? TMO : ack_delay(a);
  endfunction

  function automatic logic [DW-1:0] rom(input logic [DW-1:0] a);
    return (a ^ 32'h5A5A_C3C3) * 32'h9E37_79B1 + 32'h0000_1234;
  endfunction

  typedef struct { logic [DW-1:0] data; logic err; } resp_t;
  typedef struct { logic [DW-1:0] a; logic [DW-1:0] b; logic wr; } acc_t;

  resp_t exp_q0[$], exp_q1[$];
  acc_t  acc_q0[$], acc_q1[$];

  // ---------------- memory model ----------------
  int mm_busy = 0;
  initial begin
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd | mem_wr) begin
        mm_busy++;
        if (ack_delay(mem_a) != 0 && mm_busy == ack_delay(mem_a)) begin
          mem_ack  = 1'b1;
          mem_data = rom(mem_a);
        end else begin
          mem_ack  = 1'b0;
          mem_data = $urandom;
        end
      end else begin
        // stray acknowledges outside an access must be ignored
        mm_busy  = 0;
        mem_ack  = 1'($urandom_range(0, 1));
        mem_data = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  bit       mon_en = 1'b0;
  int       last_served;
  bit       prev_req0, prev_req1, prev_strobe;
  bit       ack_due;
  int       due_owner, cur_owner, cur_len, strobe_cycles, exp_owner;
  bit       first_seen;
  logic [1:0] first_grant;
  acc_t     cur;
  resp_t    rsp;

  task automatic mon_reset();
    exp_q0.delete(); exp_q1.delete(); acc_q0.delete(); acc_q1.delete();
    last_served = 1;
    prev_req0 = 0; prev_req1 = 0; prev_strobe = 0;
    ack_due = 0; strobe_cycles = 0; first_seen = 0; first_grant = 2'b00;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        // response side
        if (ack_due) begin
          check("ack_owner", {30'd0, ack1, ack0}, due_owner == 1 ? 2'b10 : 2'b01);
          ack_due = 0;
        end else if (ack0 | ack1) begin
          fail_now("unexpected_ack");
        end
        if (ack0) begin
          if (exp_q0.size() == 0) fail_now("ack0_no_expectation");
          else begin
            rsp = exp_q0.pop_front();
            check("req0_data", data_out, rsp.data);
            check("req0_err", {31'd0, err0}, {31'd0, rsp.err});
          end
          last_served = 0;
        end
        if (ack1) begin
          if (exp_q1.size() == 0) fail_now("ack1_no_expectation");
          else begin
            rsp = exp_q1.pop_front();
            check("req1_data", data_out, rsp.data);
            check("req1_err", {31'd0, err1}, {31'd0, rsp.err});
          end
          last_served = 1;
        end
        // memory side
        if (mem_rd | mem_wr) begin
          if (!prev_strobe) begin
            if (!prev_req0 && !prev_req1) fail_now("grant_without_request");
            exp_owner = (prev_req0 && prev_req1) ? (last_served == 1 ? 0 : 1)
                                                 : (prev_req1 ? 1 : 0);
            check("grant", {30'd0, grant}, exp_owner == 1 ? 2'b10 : 2'b01);
            if (!first_seen) begin first_seen = 1; first_grant = grant; end
            cur_owner = exp_owner;
            if ((cur_owner == 0 ? acc_q0.size() : acc_q1.size()) == 0) begin
              fail_now("access_no_expectation");
              cur = '{a: mem_a, b: mem_b, wr: mem_wr};
            end else begin
              cur = (cur_owner == 0) ? acc_q0.pop_front() : acc_q1.pop_front();
            end
            cur_len = strobe_len(cur.a);
            strobe_cycles = 0;
            check("mem_a", mem_a, cur.a);
            check("strobe_kind", {30'd0, mem_wr, mem_rd}, cur.wr ? 2'b10 : 2'b01);
            if (cur.wr) check("mem_b", mem_b, cur.b);
          end
          strobe_cycles++;
          if (strobe_cycles > TMO) fail_now("strobe_too_long");
          if (mem_ack || strobe_cycles == TMO) begin
            check("strobe_len", strobe_cycles, cur_len);
            ack_due = 1;
            due_owner = cur_owner;
          end
        end
        prev_strobe = mem_rd | mem_wr;
        prev_req0   = rd0 | wr0;
        prev_req1   = rd1 | wr1;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input int r, input logic rd, input logic wr,
                       input logic [DW-1:0] a, input logic [DW-1:0] b);
    if (r == 0) begin rd0 = rd; wr0 = wr; a0 = a; b0 = b; end
    else        begin rd1 = rd; wr1 = wr; a1 = a; b1 = b; end
  endtask

  function automatic logic [DW-1:0] gen_addr();
    logic [DW-1:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0:       x[4:0] = 5'h1F;
      1:       x[4:0] = 5'h1E;
      2:       x[4:0] = 5'h1D;
      default: x[4:0] = 5'($urandom_range(0, 28));
    endcase
    return x;
  endfunction

  task automatic push_txn(input int r, input logic rd, input logic wr,
                          input logic [DW-1:0] a, input logic [DW-1:0] b);
    resp_t e;
    acc_t  c;
    c.a = a; c.b = b; c.wr = wr & ~rd;
    e.err  = is_tmo(a);
    e.data = (c.wr || e.err) ? '0 : rom(a);
    if (r == 0) begin exp_q0.push_back(e); acc_q0.push_back(c); end
    else        begin exp_q1.push_back(e); acc_q1.push_back(c); end
  endtask

  task automatic requester(input int r, input int n);
    for (int i = 0; i < n; i++) begin
      int gap, k, t;
      logic rd, wr;
      logic [DW-1:0] a, b;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      k  = $urandom_range(0, 9);
      rd = (k < 5) || (k == 9);
      wr = (k >= 5);
      a  = gen_addr();
      b  = $urandom;
      push_txn(r, rd, wr, a, b);
      drive(r, rd, wr, a, b);
      t = 0;
      do begin @(posedge clk); #1; t++; end
      while (!(r == 1 ? ack1 : ack0) && t < 100);
      if (t >= 100) fail_now($sformatf("req%0d_ack_timeout", r));
      drive(r, 1'b0, 1'b0, $urandom, $urandom);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int t;
    bit done0, done1;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;

    // reset values
    check("rst_grant", {30'd0, grant}, 2'b00);
    check("rst_mem_rd", {31'd0, mem_rd}, 0);
    check("rst_mem_wr", {31'd0, mem_wr}, 0);
    check("rst_ack0", {31'd0, ack0}, 0);
    check("rst_ack1", {31'd0, ack1}, 0);
    check("rst_err0", {31'd0, err0}, 0);
    check("rst_err1", {31'd0, err1}, 0);
    check("rst_data", data_out, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_b", mem_b, 0);

    rst_n = 1'b1;
    @(posedge clk); #1;

    // tie straight after reset: req0 first, then req1
    mon_reset();
    mon_en = 1'b1;
    push_txn(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    push_txn(1, 1'b1, 1'b0, 32'h0000_0204, 32'h0);
    drive(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    drive(1, 1'b1, 1'b0, 32'h0000_0204, 32'h0);
    done0 = 0; done1 = 0; t = 0;
    while (!(done0 && done1) && t < 40) begin
      @(posedge clk); #1; t++;
      if (ack0) begin done0 = 1; drive(0, 1'b0, 1'b0, '0, '0); end
      if (ack1) begin done1 = 1; drive(1, 1'b0, 1'b0, '0, '0); end
    end
    if (!(done0 && done1)) fail_now("tie_ack_timeout");
    check("tie_first_grant", {30'd0, first_grant}, 2'b01);

    // randomized traffic from both requesters
    fork
      requester(0, 40);
      requester(1, 40);
    join
    repeat (4) begin @(posedge clk); #1; end
    check("exp_q0_drained", exp_q0.size(), 0);
    check("exp_q1_drained", exp_q1.size(), 0);
    check("acc_q0_drained", acc_q0.size(), 0);
    check("acc_q1_drained", acc_q1.size(), 0);
    mon_en = 1'b0;

    // reset in the second BUSY cycle, then re-arbitration of the held request
    drive(0, 1'b1, 1'b0, 32'h0000_003F, 32'h0);
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!mem_rd && t < 10);
    if (!mem_rd) fail_now("midrst_no_strobe");
    @(posedge clk); #1;
    check("midrst_busy2_rd", {31'd0, mem_rd}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_rd", {31'd0, mem_rd}, 0);
    check("midrst_wr", {31'd0, mem_wr}, 0);
    check("midrst_grant", {30'd0, grant}, 2'b00);
    check("midrst_ack0", {31'd0, ack0}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rearb_rd", {31'd0, mem_rd}, 1);
    check("rearb_grant", {30'd0, grant}, 2'b01);
    check("rearb_addr", mem_a, 32'h0000_003F);
    t = 0;
    do begin @(posedge clk); #1; t++; end while (!ack0 && t < 30);
    check("rearb_tmo_cycles", t, TMO);
    check("rearb_ack0", {31'd0, ack0}, 1);
    check("rearb_err0", {31'd0, err0}, 1);
    check("rearb_data", data_out, 0);
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (2) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

endmodule
